segment_scroller: RTL and testbench

Sequencer that feeds the four-digit multiplexed seven-segment driver. A producer writes a message of per-digit segment patterns into an internal buffer over a valid/ready handshake. On `start`, the block scrolls the message right-to-left across the four digit inputs `c3..c0` of the digit multiplexer, advancing one position every `STEP_CYCLES` clocks. It sits between the control logic and the display multiplexer, and owns all four digit pattern registers.

---
 rtl/segment_scroller.sv | 139 +++++++++++++
 tb/tb_segment_scroller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/segment_scroller.sv
// Scrolls a buffered message of seven-segment patterns right-to-left across four digits.
// Define SCROLL_LOOP_EN to let loop_en repeat the message; otherwise loop_en is ignored.
module segment_scroller #(
    parameter int          DEPTH       = 16,
    parameter int          STEP_CYCLES = 25_000_000,
    parameter logic [7:0]  BLANK       = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       start,
    input  logic       abort,
    input  logic       loop_en,
    output logic       busy,
    output logic       done,
    output logic [7:0] c3,
    output logic [7:0] c2,
    output logic [7:0] c1,
    output logic [7:0] c0
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH + 4);
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, SCROLL} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [DEPTH];
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] pos, pos_next;
    logic [SW-1:0] step, step_next;
    logic          wr_fire, boundary, last_pos, loop_eff, done_next;
    logic [7:0]    c_next [4];

`ifdef SCROLL_LOOP_EN
    assign loop_eff = loop_en;
`else
    logic unused_loop_en;
    assign loop_eff       = 1'b0;
    assign unused_loop_en = loop_en;
`endif

    assign wr_ready = (state == IDLE) && (count < CW'(DEPTH));
    assign wr_fire  = wr_valid && wr_ready;
    assign boundary = (step == SW'(STEP_CYCLES - 1));
    assign last_pos = (int'(pos) >= int'(count) + 3);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        count_next = count;
        pos_next   = pos;
        step_next  = step;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (wr_fire)
                    count_next = count + 1'b1;
                if (start && (count != '0 || wr_fire)) begin
                    state_next = SCROLL;
                    pos_next   = PW'(1);
                    step_next  = '0;
                end
            end
            SCROLL: begin
                if (abort) begin
                    state_next = IDLE;
                    count_next = '0;
                    pos_next   = '0;
                    step_next  = '0;
                end else if (boundary) begin
                    step_next = '0;
                    if (!last_pos) begin
                        pos_next = pos + 1'b1;
                    end else if (loop_eff) begin
                        pos_next = PW'(1);
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        count_next = '0;
                        pos_next   = '0;
                    end
                end else begin
                    step_next = step + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Digit d shows stream element pos+d; the pattern written on a start edge is forwarded.
    always_comb begin
        int idx;
        for (int d = 0; d < 4; d++) begin
            idx       = int'(pos_next) + d - 4;
            c_next[d] = BLANK;
            if (state_next == SCROLL && idx >= 0 && idx < int'(count_next))
                c_next[d] = (wr_fire && idx == int'(count)) ? wr_data : mem[idx[IW-1:0]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            pos   <= '0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            c3    <= BLANK;
            c2    <= BLANK;
            c1    <= BLANK;
            c0    <= BLANK;
        end else begin
            state <= state_next;
            count <= count_next;
            pos   <= pos_next;
            step  <= step_next;
            busy  <= (state_next == SCROLL);
            done  <= done_next;
            c3    <= c_next[0];
            c2    <= c_next[1];
            c1    <= c_next[2];
            c0    <= c_next[3];
        end
    end

    // NOTE: the buffer is not reset; entries at or beyond count are never displayed.
    always_ff @(posedge clock) begin
        if (wr_fire)
            mem[count[IW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_segment_scroller.sv
// Scoreboard bench for segment_scroller: expected display frames are queued at start and compared per cycle.
module tb_segment_scroller;

    localparam int         DEPTH       = 4;
    localparam int         STEP_CYCLES = 3;
    localparam logic [7:0] BLANK       = 8'hFF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       loop_en = 1'b0;
    logic       busy, done;
    logic [7:0] c3, c2, c1, c0;

    int vectors     = 0;
    int miscompares = 0;

    logic [33:0] sb[$];
    logic [7:0]  model_msg[$];

    localparam logic [33:0] IDLE_FRAME = {{4{BLANK}}, 2'b00};
    localparam logic [33:0] DONE_FRAME = {{4{BLANK}}, 2'b01};

    segment_scroller #(.DEPTH(DEPTH), .STEP_CYCLES(STEP_CYCLES), .BLANK(BLANK)) dut (
        .clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .start(start), .abort(abort), .loop_en(loop_en), .busy(busy), .done(done),
        .c3(c3), .c2(c2), .c1(c1), .c0(c0)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [33:0] dut_frame();
        return {c3, c2, c1, c0, busy, done};
    endfunction

    // Expected (c3,c2,c1,c0,busy,done) at scroll position p from the model message.
    function automatic logic [33:0] exp_frame(int p);
        logic [31:0] pats = '0;
        for (int d = 0; d < 4; d++) begin
            int i = p + d;
            logic [7:0] b = BLANK;
            if (i >= 4 && i < 4 + model_msg.size())
                b = model_msg[i - 4];
            pats = {pats[23:0], b};
        end
        return {pats, 2'b10};
    endfunction

    task automatic push_scroll(input int passes);
        for (int pass = 0; pass < passes; pass++)
            for (int p = 1; p <= model_msg.size() + 3; p++)
                repeat (STEP_CYCLES) sb.push_back(exp_frame(p));
        sb.push_back(DONE_FRAME);
        sb.push_back(IDLE_FRAME);
    endtask

    task automatic drain(input int n, input bit first_step);
        for (int i = 0; i < n; i++) begin
            if (i > 0 || first_step)
                step();
            if (sb.size() == 0)
                check("sb_underflow", 64'd1, 64'd0);
            else
                check("frame", 64'(dut_frame()), 64'(sb.pop_front()));
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        check("wr_ready_write", 64'(wr_ready), 64'd1);
        step();
        wr_valid = 1'b0;
        model_msg.push_back(b);
    endtask

    initial begin
        // Reset
        step();
        step();
        reset = 1'b0;
        check("reset_frame", 64'(dut_frame()), 64'(IDLE_FRAME));
        check("reset_wr_ready", 64'(wr_ready), 64'd1);

        // Fill with wr_valid held, then a refused fifth write
        wr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_data = 8'(k + 1);
            check("fill_wr_ready", 64'(wr_ready), 64'd1);
            check("fill_frame", 64'(dut_frame()), 64'(IDLE_FRAME));
            step();
            model_msg.push_back(8'(k + 1));
        end
        check("full_wr_ready", 64'(wr_ready), 64'd0);
        wr_data = 8'h05;
        step();
        check("full_refused", 64'(wr_ready), 64'd0);
        check("full_frame", 64'(dut_frame()), 64'(IDLE_FRAME));
        wr_valid = 1'b0;
        push_scroll(1);
        start = 1'b1;
        step();
        start = 1'b0;
        drain(7 * STEP_CYCLES + 2, 1'b0);
        model_msg.delete();

        // Two-pattern scroll
        write_byte(8'hA1);
        write_byte(8'hA2);
        push_scroll(1);
        start = 1'b1;
        step();
        start = 1'b0;
        drain(5 * STEP_CYCLES + 2, 1'b0);
        model_msg.delete();

        // Start with empty buffer is ignored; write + start together runs with count 1
        start = 1'b1;
        step();
        start = 1'b0;
        check("empty_start_frame", 64'(dut_frame()), 64'(IDLE_FRAME));
        step();
        check("empty_start_busy", 64'(busy), 64'd0);
        wr_data  = 8'h55;
        wr_valid = 1'b1;
        start    = 1'b1;
        model_msg.push_back(8'h55);
        push_scroll(1);
        step();
        wr_valid = 1'b0;
        start    = 1'b0;
        drain(4 * STEP_CYCLES + 2, 1'b0);
        model_msg.delete();

        // Abort on the position-2 step boundary
        write_byte(8'hA1);
        write_byte(8'hA2);
        for (int p = 1; p <= 2; p++)
            repeat (STEP_CYCLES) sb.push_back(exp_frame(p));
        sb.push_back(IDLE_FRAME);
        start = 1'b1;
        step();
        start = 1'b0;
        drain(2 * STEP_CYCLES, 1'b0);
        abort = 1'b1;
        drain(1, 1'b1);
        abort = 1'b0;
        check("abort_wr_ready", 64'(wr_ready), 64'd1);
        model_msg.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        check("abort_count_zero", 64'(busy), 64'd0);

        // Looping (feature build) or loop_en ignored (default build)
        write_byte(8'h3C);
        loop_en = 1'b1;
`ifdef SCROLL_LOOP_EN
        push_scroll(3);
        start = 1'b1;
        step();
        start = 1'b0;
        drain(8 * STEP_CYCLES, 1'b0);
        drain(1, 1'b1);
        loop_en = 1'b0;
        drain(4 * STEP_CYCLES + 1, 1'b1);
`else
        push_scroll(1);
        start = 1'b1;
        step();
        start = 1'b0;
        drain(4 * STEP_CYCLES + 2, 1'b0);
`endif
        loop_en = 1'b0;
        model_msg.delete();

        // Reset in the middle of a scroll
        write_byte(8'hA1);
        write_byte(8'hA2);
        repeat (STEP_CYCLES) sb.push_back(exp_frame(1));
        sb.push_back(exp_frame(2));
        sb.push_back(IDLE_FRAME);
        start = 1'b1;
        step();
        start = 1'b0;
        drain(STEP_CYCLES + 1, 1'b0);
        reset = 1'b1;
        drain(1, 1'b1);
        check("midreset_wr_ready", 64'(wr_ready), 64'd1);
        reset = 1'b0;
        step();
        check("post_reset_frame", 64'(dut_frame()), 64'(IDLE_FRAME));
        model_msg.delete();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
